// File: rtl/seg7_pkg.sv
// Shared types, glyph table and sizing helper for the signed scanning 7-segment display.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  // {a,b,c,d,e,f,g,dp}, active-low
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
    8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00011001
  };
  localparam logic [7:0] SEG_MINUS = 8'b11111101;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'b01100001;

  // ceil(width * log10(2)) in integer arithmetic
  function automatic int unsigned bcd_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seg7_signed_scan_if.sv
// Load/status bundle between a datapath producer and the scanning display.
interface seg7_signed_scan_if #(
  parameter int unsigned DATA_W = 12
);
  logic              load;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              overflow;

  modport master (output load, value, input busy, overflow);
  modport slave  (input load, value, output busy, overflow);
endinterface

// File: rtl/seg7_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, DATA_W steps.
module seg7_bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter  int unsigned DATA_W = 12,
  localparam int unsigned NB     = bcd_digits(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              done,
  output logic [4*NB-1:0]   bcd
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic              running;
  logic [CNT_W-1:0]  step_cnt;
  logic [DATA_W-1:0] bin_sh;
  logic [4*NB-1:0]   bcd_adj;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < NB; i++) begin
      if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = running && (step_cnt == CNT_W'(DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      step_cnt <= '0;
      bin_sh   <= '0;
      bcd      <= '0;
    end else if (start) begin
      // The first step on an all-zero BCD field is a plain shift, so it is folded into the load.
      running  <= 1'b1;
      step_cnt <= CNT_W'(1);
      bcd      <= {{(4*NB-1){1'b0}}, bin[DATA_W-1]};
      bin_sh   <= bin << 1;
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
      end else begin
        bcd      <= {bcd_adj[4*NB-2:0], bin_sh[DATA_W-1]};
        bin_sh   <= bin_sh << 1;
        step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg7_signed_scan.sv
// N-digit multiplexed common-anode display of a signed value with sign, blanking and overflow.
module seg7_signed_scan
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_signed_scan_if.slave   bus,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int unsigned NB    = bcd_digits(DATA_W);
  localparam int unsigned PAD_N = (NB > N_DIGITS) ? NB : N_DIGITS;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t            state;
  logic              busy_q;
  logic              ovf_q;
  logic              conv_sign;
  logic              start;
  logic [DATA_W-1:0] mag;
  logic              eng_done;
  logic [4*NB-1:0]   eng_bcd;
  logic [4*PAD_N-1:0] bcd_pad;
  bcd_t              new_dig [N_DIGITS];
  logic              new_ovf;

  bcd_t              disp_dig [N_DIGITS];
  logic              disp_sign;

  logic [IDX_W-1:0]  scan_idx;
  logic [CNT_W-1:0]  scan_cnt;
  logic              lz;
  bcd_t              cur_dig;
  logic [7:0]        glyph;

  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign start        = (state == IDLE) && bus.load;

  // Negating -2^(DATA_W-1) wraps to itself, which is the correct magnitude read as unsigned.
  assign mag = bus.value[DATA_W-1] ? (~bus.value + DATA_W'(1)) : bus.value;

  seg7_bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (mag),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  assign bcd_pad = (4*PAD_N)'(eng_bcd);

  always_comb begin
    new_ovf = 1'b0;
    for (int unsigned j = 0; j < PAD_N; j++) begin
      if (j >= (conv_sign ? N_DIGITS - 1 : N_DIGITS) && bcd_pad[4*j +: 4] != '0) new_ovf = 1'b1;
    end
    for (int unsigned i = 0; i < N_DIGITS; i++) new_dig[i] = bcd_pad[4*i +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      conv_sign <= 1'b0;
      disp_sign <= 1'b0;
      disp_dig  <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            conv_sign <= bus.value[DATA_W-1];
            busy_q    <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          if (eng_done) begin
            disp_dig  <= new_dig;
            disp_sign <= conv_sign;
            ovf_q     <= new_ovf;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cur_dig = disp_dig[scan_idx];

  always_comb begin
    lz = 1'b1;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (j >= 32'(scan_idx) && !(disp_sign && j == N_DIGITS - 1) && disp_dig[j] != '0) lz = 1'b0;
    end
    if (ovf_q)                                            glyph = SEG_E;
    else if (disp_sign && scan_idx == IDX_W'(N_DIGITS-1)) glyph = SEG_MINUS;
    else if (BLANK_LZ && scan_idx != '0 && lz)            glyph = SEG_BLANK;
    else if (cur_dig > 4'd9)                              glyph = SEG_BLANK;
    else                                                  glyph = SEG_DIGIT[cur_dig];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx <= '0;
      scan_cnt <= '0;
      seg      <= SEG_BLANK;
      an       <= '1;
    end else begin
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
      seg <= glyph;
      an  <= ~(N_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_seg7_signed_scan.sv
// Bench for seg7_signed_scan: directed and random loads against a decimal-arithmetic display model.
module tb_seg7_signed_scan;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 12;
  localparam int unsigned DIV = 4;

  localparam logic [7:0] GLYPH [10] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
    8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00011001
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_signed_scan_if #(.DATA_W(W)) bus ();
  seg7_signed_scan_if #(.DATA_W(W)) bus_nb ();

  logic [7:0]   seg, seg_nb;
  logic [N-1:0] an, an_nb;

  seg7_signed_scan #(.N_DIGITS(N), .DATA_W(W), .SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .seg(seg), .an(an)
  );

  seg7_signed_scan #(.N_DIGITS(N), .DATA_W(W), .SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus_nb), .seg(seg_nb), .an(an_nb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    repeat (e) r *= 10;
    return r;
  endfunction

  function automatic bit exp_ovf(input int v);
    int a = (v < 0) ? -v : v;
    return (v < 0) ? (a >= pow10(N - 1)) : (a >= pow10(N));
  endfunction

  function automatic logic [7:0] exp_glyph(input int v, input int i, input bit blz);
    int a = (v < 0) ? -v : v;
    if (exp_ovf(v))                          return 8'b01100001;
    if (v < 0 && i == N - 1)                 return 8'b11111101;
    if (blz && i > 0 && a / pow10(i) == 0)   return 8'hFF;
    return GLYPH[(a / pow10(i)) % 10];
  endfunction

  task automatic do_load(input int v);
    @(negedge clk);
    bus.load = 1'b1;    bus.value    = W'(v);
    bus_nb.load = 1'b1; bus_nb.value = W'(v);
    @(negedge clk);
    bus.load = 1'b0;    bus_nb.load  = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_display(input string tag, input int v, input bit nb);
    for (int i = 0; i < N; i++) begin
      int guard = 0;
      logic [N-1:0] want = ~(N'(1) << i);
      while ((nb ? an_nb : an) !== want && guard < 4 * N * DIV + 4) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("%s an%0d", tag, i), 32'(nb ? an_nb : an), 32'(want));
      check($sformatf("%s d%0d", tag, i), 32'(nb ? seg_nb : seg), 32'(exp_glyph(v, i, !nb)));
    end
    check($sformatf("%s ovf", tag), 32'(nb ? bus_nb.overflow : bus.overflow), 32'(exp_ovf(v)));
  endtask

  task automatic load_and_check(input string tag, input int v);
    int cnt;
    do_load(v);
    wait_idle(cnt);
    check($sformatf("%s busy_len", tag), 32'(cnt), 32'(W));
    check_display(tag, v, 1'b0);
  endtask

  logic [N-1:0] an_log [24];

  initial begin
    int cnt, j, busy_seen, v;
    bus.load = 1'b0;    bus.value    = '0;
    bus_nb.load = 1'b0; bus_nb.value = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst seg", 32'(seg), 32'hFF);
    check("rst an", 32'(an), 32'hF);
    check("rst busy", 32'(bus.busy), 0);
    check("rst ovf", 32'(bus.overflow), 0);

    // Scan order after release
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      an_log[c] = an;
    end
    check("scan first", 32'(an_log[0]), 32'hE);
    j = 1;
    while (j < 20 && an_log[j] == an_log[0]) j++;
    check("scan first run", 32'(j >= 1 && j <= int'(DIV)), 1);
    for (int m = 0; m < 12; m++)
      check($sformatf("scan m%0d", m), 32'(an_log[j + m]), 32'(4'(~(4'b1 << ((1 + m / DIV) % N)))));
    check_display("zero", 0, 1'b0);
    check_display("zero_nb", 0, 1'b1);

    // Directed values
    load_and_check("1234", 1234);
    load_and_check("m5", -5);
    load_and_check("m999", -999);
    load_and_check("m1000", -1000);
    load_and_check("m2048", -2048);
    load_and_check("max", 2047);

    // Load while busy is dropped
    do_load(7);
    repeat (3) @(negedge clk);
    bus.load = 1'b1;    bus.value    = W'(42);
    bus_nb.load = 1'b1; bus_nb.value = W'(42);
    @(negedge clk);
    bus.load = 1'b0;    bus_nb.load  = 1'b0;
    wait_idle(cnt);
    check("busy_drop len", 32'(cnt), 32'(W - 4));
    check_display("seven", 7, 1'b0);
    check_display("seven_nb", 7, 1'b1);

    // Load on the commit edge is dropped
    do_load(100);
    repeat (W - 1) @(negedge clk);
    bus.load = 1'b1;    bus.value    = W'(55);
    bus_nb.load = 1'b1; bus_nb.value = W'(55);
    @(negedge clk);
    bus.load = 1'b0;    bus_nb.load  = 1'b0;
    check("commit_edge busy", 32'(bus.busy), 0);
    check_display("hundred", 100, 1'b0);

    // Random values
    for (int r = 0; r < 16; r++) begin
      v = int'($urandom_range(0, (1 << W) - 1));
      if (v >= (1 << (W - 1))) v -= (1 << W);
      load_and_check($sformatf("rnd%0d", r), v);
    end

    // Reset during conversion
    load_and_check("pre_rst", -5);
    do_load(1234);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst seg", 32'(seg), 32'hFF);
    check("mid_rst an", 32'(an), 32'hF);
    check("mid_rst busy", 32'(bus.busy), 0);
    check("mid_rst ovf", 32'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("post_rst busy", 32'(busy_seen), 0);
    check_display("post_rst", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
